// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter controller: FSM state encoding and parameter defaults.
package counter_ctrl_pkg;

    localparam int TERM_MAX_DEF = 128;
    localparam int RND_W_DEF    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/counter_ctrl_core.sv
// counter_core: the Q register. Counts 0..term, then returns to 0 with a one-cycle wrap pulse.
module counter_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] Q,
    output logic             wrap
);

    // clr beats en so an abort or a fresh start never produces a wrap.
    always_ff @(posedge clk) begin
        if (clr) begin
            Q    <= '0;
            wrap <= 1'b0;
        end else if (en) begin
            if (Q == term) begin
                Q    <= '0;
                wrap <= 1'b1;
            end else begin
                Q    <= Q + 1'b1;
                wrap <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: run controller (FSM, config registers, round counter) around counter_core.
// Optional macro COUNTER_CTRL_IRQ_EN adds a sticky done interrupt (irq / irq_clr).
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int TERM_MAX = TERM_MAX_DEF,
    parameter int RND_W    = RND_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_term,
    input  logic [RND_W-1:0] cfg_rounds,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    output logic             busy,
    output logic [WIDTH-1:0] Q,
    output logic             wrap,
`ifdef COUNTER_CTRL_IRQ_EN
    input  logic             irq_clr,
    output logic             irq,
`endif
    output logic             done,
    output logic [1:0]       state_dbg
);

    // Handshake: a config word is taken on any edge where cfg_valid && cfg_ready (only in IDLE).
    localparam logic [WIDTH-1:0] TERM_CLAMP = WIDTH'(TERM_MAX);

    state_e           state, state_nxt;
    logic [WIDTH-1:0] term_r;
    logic [RND_W-1:0] rounds_r;
    logic [RND_W-1:0] rnd_cnt;
    logic             cfg_fire, launch, running, cnt_en, at_term, last_wrap, core_clr;

    assign cfg_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

    assign cfg_fire  = cfg_valid && cfg_ready;
    assign launch    = start && cfg_ready;
    assign running   = (state == ST_RUN) || (state == ST_PAUSE);
    assign cnt_en    = running && !abort && !pause;
    assign at_term   = (Q == term_r);
    // rnd_cnt == 0 means run forever, so only a count of 1 can finish a run.
    assign last_wrap = cnt_en && at_term && (rnd_cnt == RND_W'(1));
    assign core_clr  = rst || launch || (running && abort);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:           if (launch) state_nxt = ST_RUN;
            ST_RUN, ST_PAUSE: begin
                if (abort)          state_nxt = ST_IDLE;
                else if (pause)     state_nxt = ST_PAUSE;
                else if (last_wrap) state_nxt = ST_DONE;
                else                state_nxt = ST_RUN;
            end
            ST_DONE:           state_nxt = ST_IDLE;
            default:           state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            term_r   <= TERM_CLAMP;
            rounds_r <= '0;
            rnd_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (cfg_fire) begin
                term_r   <= (cfg_term > TERM_CLAMP) ? TERM_CLAMP : cfg_term;
                rounds_r <= cfg_rounds;
            end
            // A config taken on the launch edge applies to that same run.
            if (launch)
                rnd_cnt <= cfg_fire ? cfg_rounds : rounds_r;
            else if (cnt_en && at_term && (rnd_cnt != '0))
                rnd_cnt <= rnd_cnt - 1'b1;
        end
    end

`ifdef COUNTER_CTRL_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst)          irq <= 1'b0;
        else if (done)    irq <= 1'b1;
        else if (irq_clr) irq <= 1'b0;
    end
`endif

    counter_core #(.WIDTH(WIDTH)) u_core (
        .clk  (clk),
        .clr  (core_clr),
        .en   (cnt_en),
        .term (term_r),
        .Q    (Q),
        .wrap (wrap)
    );

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed scenarios then random traffic against a run-level model.
module tb_counter_ctrl;

    localparam int WIDTH    = 8;
    localparam int TERM_MAX = 128;
    localparam int RND_W    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_term = '0;
    logic [RND_W-1:0] cfg_rounds = '0;
    logic             start = 1'b0;
    logic             pause = 1'b0;
    logic             abort = 1'b0;
    logic             busy;
    logic [WIDTH-1:0] Q;
    logic             wrap;
    logic             done;
    logic [1:0]       state_dbg;
`ifdef COUNTER_CTRL_IRQ_EN
    logic             irq_clr = 1'b0;
    logic             irq;
    bit               m_irq;
`endif

    int checks   = 0;
    int failures = 0;

    // Run-level model: is a run in progress, how many wraps remain, and the visible outputs.
    bit m_active, m_done, m_wrap;
    int m_q, m_term, m_rounds, m_left;

    always #5 clk = ~clk;

    counter_ctrl #(.WIDTH(WIDTH), .TERM_MAX(TERM_MAX), .RND_W(RND_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_term   (cfg_term),
        .cfg_rounds (cfg_rounds),
        .start      (start),
        .pause      (pause),
        .abort      (abort),
        .busy       (busy),
        .Q          (Q),
        .wrap       (wrap),
`ifdef COUNTER_CTRL_IRQ_EN
        .irq_clr    (irq_clr),
        .irq        (irq),
`endif
        .done       (done),
        .state_dbg  (state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
`ifdef COUNTER_CTRL_IRQ_EN
        if (rst) m_irq = 0;
        else if (m_done) m_irq = 1;
        else if (irq_clr) m_irq = 0;
`endif
        m_wrap = 0;
        if (rst) begin
            m_active = 0; m_done = 0; m_q = 0;
            m_term = TERM_MAX; m_rounds = 0; m_left = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (cfg_valid) begin
                m_term   = (int'(cfg_term) > TERM_MAX) ? TERM_MAX : int'(cfg_term);
                m_rounds = int'(cfg_rounds);
            end
            if (start) begin
                m_active = 1; m_q = 0; m_left = m_rounds;
            end
        end else if (abort) begin
            m_active = 0; m_q = 0;
        end else if (!pause) begin
            if (m_q == m_term) begin
                m_q = 0; m_wrap = 1;
                if (m_left != 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_active = 0; m_done = 1;
                    end
                end
            end else begin
                m_q = (m_q + 1) % (1 << WIDTH);
            end
        end
    endtask

    task automatic check_all();
        bit exp_busy;
        exp_busy = m_active || m_done;
        chk("q", 32'(Q), 32'(m_q));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("done", 32'(done), 32'(m_done));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("cfg_ready", 32'(cfg_ready), 32'(!exp_busy));
        chk("idle_dbg", 32'(state_dbg == 2'd0), 32'(!exp_busy));
`ifdef COUNTER_CTRL_IRQ_EN
        chk("irq", 32'(irq), 32'(m_irq));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic configure(input int term, input int rounds, input bit with_start);
        cfg_valid = 1; cfg_term = WIDTH'(term); cfg_rounds = RND_W'(rounds); start = with_start;
        tick();
        cfg_valid = 0; start = 0;
    endtask

    task automatic run_until_q(input int target, input int budget);
        int n = 0;
        while (m_q != target && n < budget) begin
            tick();
            n++;
        end
        chk("reach_q", 32'(Q), 32'(target));
    endtask

    initial begin
        // Reset
        rst = 1;
        ticks(2);
        rst = 0;
        tick();

        // Start with reset defaults is exercised later; first a two-round run at term 128.
        configure(128, 2, 0);
        start = 1; tick(); start = 0;
        ticks(262);

        // Over-range term clamps to TERM_MAX; config and start on the same edge.
        configure(200, 1, 1);
        ticks(132);

        // Pause held three cycles at Q=3 with term 5.
        configure(5, 0, 1);
        run_until_q(3, 20);
        pause = 1; ticks(3); pause = 0;
        ticks(4);
        abort = 1; tick(); abort = 0;
        tick();

        // Abort at Q=50.
        configure(100, 0, 1);
        run_until_q(50, 80);
        abort = 1; tick(); abort = 0;
        ticks(3);

        // Reset in the middle of a run.
        configure(60, 3, 1);
        run_until_q(10, 20);
        rst = 1; tick(); rst = 0;
        ticks(2);

        // Start with defaults after reset, then abort from PAUSE.
        start = 1; tick(); start = 0;
        ticks(5);
        pause = 1; ticks(2);
        abort = 1; tick(); abort = 0; pause = 0;
        tick();

        // term 0, forever: wrap every cycle, no done.
        configure(0, 0, 1);
        ticks(10);
        start = 1; tick(); start = 0;
        abort = 1; tick(); abort = 0;

        // Short finite run; clear request coincides with the done cycle.
        configure(1, 1, 1);
        for (int i = 0; i < 10 && !m_done; i++) tick();
        chk("done_seen", 32'(done), 32'd1);
`ifdef COUNTER_CTRL_IRQ_EN
        irq_clr = 1; tick(); irq_clr = 0;
        ticks(2);
        irq_clr = 1; tick(); irq_clr = 0;
`else
        ticks(3);
`endif

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_term  = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 6))
                                                    : WIDTH'($urandom_range(0, 255));
            cfg_rounds = RND_W'($urandom_range(0, 3));
            start     = ($urandom_range(0, 4) == 0);
            pause     = ($urandom_range(0, 7) == 0);
            abort     = ($urandom_range(0, 99) == 0);
`ifdef COUNTER_CTRL_IRQ_EN
            irq_clr   = ($urandom_range(0, 9) == 0);
`endif
            tick();
        end
        rst = 0; cfg_valid = 0; start = 0; pause = 0; abort = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the counter width.
REQ-002 Parameter TERM_MAX, default 128, SHALL set the largest legal terminal count.
REQ-003 Parameter RND_W, default 4, SHALL set the round-counter width.
REQ-004 Port clk, input, 1: SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: SHALL be the reset, synchronous and active-high.
REQ-006 Port cfg_valid, input, 1: SHALL mark cfg_term/cfg_rounds valid.
REQ-007 Port cfg_ready, output, 1: SHALL indicate that configuration is accepted.
REQ-008 Port cfg_term, input, WIDTH: SHALL be the terminal count.
REQ-009 Port cfg_rounds, input, RND_W: SHALL be the wrap count before done; 0 = run forever.
REQ-010 Port start, input, 1: SHALL request a run.
REQ-011 Port pause, input, 1: SHALL hold the count while high.
REQ-012 Port abort, input, 1: SHALL cancel a run.
REQ-013 Port busy, output, 1: SHALL be high in RUN, PAUSE and DONE.
REQ-014 Port Q, output, WIDTH: SHALL carry the current count.
REQ-015 Port wrap, output, 1: SHALL pulse for one cycle when Q returns to 0 after reaching the terminal count.
REQ-016 Port done, output, 1: SHALL pulse for one cycle in DONE.

Function
REQ-017 States SHALL be IDLE, RUN, PAUSE and DONE.
REQ-018 cfg_ready SHALL equal (state==IDLE).
- Handshake: cfg_valid && cfg_ready latches term and rounds.
- cfg_term > TERM_MAX clamps to TERM_MAX.
REQ-019 IDLE with start=1 SHALL go to RUN next cycle with Q=0 and the round counter loaded.
- start without prior config uses the reset defaults: term=TERM_MAX, rounds=0.
- Simultaneous cfg handshake and start: the new config applies to that run.
REQ-020 In RUN, Q SHALL increment by 1 per cycle while Q != term.
- At Q == term: next Q=0 and wrap=1 in that next cycle; the round counter decrements when nonzero-mode.
- term=0: Q stays 0 and wrap pulses every cycle.
REQ-021 The final wrap of a finite run (rounds reaches 0) SHALL enter DONE with Q=0.
- DONE lasts one cycle with done=1, then returns to IDLE.
REQ-022 RUN with pause=1 SHALL go to PAUSE with Q held.
- PAUSE with pause=0 SHALL return to RUN and resume counting that cycle.
REQ-023 Priority SHALL be abort > pause > count.
- abort in any non-IDLE state: IDLE next cycle, Q=0, no wrap, no done.
REQ-024 start outside IDLE SHALL be ignored.
- Arithmetic is modulo 2^WIDTH; Q never exceeds term.

Reset
REQ-025 rst SHALL force state=IDLE, Q=0, wrap=0, done=0, busy=0, term=TERM_MAX, rounds=0 (and irq=0) on the next edge.
- rst overrides all inputs.
- rst mid-run discards the run without a done pulse.

Configuration
REQ-026 Macro COUNTER_CTRL_IRQ_EN SHALL add input irq_clr (1) and output irq (1).
- irq sets on a done pulse and stays high until irq_clr=1.
- Set wins if set and clear coincide.
- Without the macro: no such ports and no irq logic.

Structure
REQ-027 Package counter_ctrl_pkg SHALL hold the state enum and the defaults TERM_MAX_DEF and RND_W_DEF.
REQ-028 Sub-module counter_core SHALL hold the Q register.
- Inputs: clr, en, term.
- Outputs: Q, wrap.
- counter_ctrl holds the FSM, config registers and round counter.

Verification
REQ-029 Directed scenarios:
- Load term=128, rounds=2, start -> Q runs 0..128; wrap at the two returns to 0; done in the same cycle as the second wrap; IDLE next.
- cfg_term=200 -> clamped: Q wraps after 128.
- Run term=5, pause held 3 cycles at Q=3 -> Q=3 for 3 cycles, then 4.
- abort at Q=50 -> Q=0 and IDLE next cycle, no done.
- rst asserted at Q=10 -> all outputs 0 next cycle, cfg_ready=1.
- rounds=0, term=0 -> wrap every cycle, done never asserts.
- With COUNTER_CTRL_IRQ_EN: done sets irq; irq_clr on the same cycle as done -> irq=1.
